// File: rtl/n64_vinfo_track_pkg.sv
// Shared definitions for the N64 video-info tracker: vinfo bit layout, sync nibble
// bit positions, the candidate decision type and an edge-decode helper.
package n64_vinfo_track_pkg;

  // Legacy vinfo layout: {data_cnt, n64_480i, vmode}
  localparam int VINFO_VMODE = 0;
  localparam int VINFO_480I  = 1;
  localparam int VINFO_DCNT  = 2;

  localparam int PAL_THRESH_DEF = 288;

  // Sync nibble layout: {nVSYNC, -, nHSYNC, -}
  localparam int SYNC_V = 3;
  localparam int SYNC_H = 1;

  typedef struct packed {
    logic n64_480i;
    logic vmode;
  } vinfo_cand_t;

  localparam vinfo_cand_t VINFO_RST = '{n64_480i: 1'b1, vmode: 1'b0};

  // Returns {posedge, negedge} of one sync line, gated by the sync-nibble cycle.
  function automatic logic [1:0] edge_pair(input logic pre, input logic cur, input logic en);
    return {en & ~pre & cur, en & pre & ~cur};
  endfunction

endpackage

// File: rtl/n64_vinfo_filter.sv
// Consecutive-match filter: a candidate must repeat LOCK_FRAMES times in a row before
// it is passed to the output; any disagreement or a timeout drops the lock.
module n64_vinfo_filter
  import n64_vinfo_track_pkg::*;
#(
  parameter int            W           = 2,
  parameter int            LOCK_FRAMES = 4,
  parameter logic [W-1:0]  RST_VAL     = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cand,
  input  logic         valid,
  input  logic         timeout,
  output logic [W-1:0] value,
  output logic         locked
);

  localparam int             SCW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [SCW-1:0] CNT_MAX = SCW'(LOCK_FRAMES);
  localparam logic [SCW-1:0] CNT_HIT = SCW'(LOCK_FRAMES - 1);

  logic [W-1:0]   prev;
  logic           has_prev;
  logic [SCW-1:0] stable_cnt;
  logic [SCW-1:0] stable_inc;
  logic           match;

  always_comb begin
    match      = has_prev && (cand == prev);
    stable_inc = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      has_prev   <= 1'b0;
      stable_cnt <= '0;
      value      <= RST_VAL;
      locked     <= 1'b0;
    end else begin
      if (valid) begin
        prev     <= cand;
        has_prev <= 1'b1;
        if (match) begin
          stable_cnt <= stable_inc;
          if (stable_inc >= CNT_HIT) begin
            value  <= cand;
            locked <= 1'b1;
          end
        end else begin
          // The first field after reset lands here too: nothing to agree with yet.
          stable_cnt <= '0;
          locked     <= 1'b0;
        end
      end
      // Losing vertical sync overrides whatever the field decision said.
      if (timeout) begin
        stable_cnt <= '0;
        locked     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/n64_vinfo_track.sv
// N64 video-info tracker: demux phase, 480i/576i, PAL/NTSC and lock from sync nibbles.
// Define N64_VINFO_LINECNT_EN to expose the last measured lines-per-field on fld_lines_o.
module n64_vinfo_track
  import n64_vinfo_track_pkg::*;
#(
  parameter int DCNT_W      = 2,
  parameter int LCNT_W      = 10,
  parameter int PAL_THRESH  = PAL_THRESH_DEF,
  parameter int LOCK_FRAMES = 4
) (
  input  logic              VCLK,
  input  logic              RST,
  input  logic              nDSYNC,
  input  logic [3:0]        Sync_pre,
  input  logic [3:0]        Sync_cur,
  output logic [DCNT_W+1:0] vinfo_o,
  output logic              locked_o,
  output logic              field_o
`ifdef N64_VINFO_LINECNT_EN
  ,
  output logic [LCNT_W-1:0] fld_lines_o
`endif
);

  localparam logic [LCNT_W-1:0] LINE_MAX = '1;
  localparam logic [LCNT_W:0]   PAL_LIM  = (LCNT_W + 1)'(PAL_THRESH);

  logic              v_pos, v_neg, h_pos, h_neg;
  logic [DCNT_W-1:0] data_cnt;
  logic [LCNT_W-1:0] line_cnt;
  logic [LCNT_W-1:0] fld_lines;
  logic              timeout;
  vinfo_cand_t       cand;
  vinfo_cand_t       vinfo_q;
  logic              sync_unused;

  assign sync_unused = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

  always_comb begin
    {v_pos, v_neg} = edge_pair(Sync_pre[SYNC_V], Sync_cur[SYNC_V], ~nDSYNC);
    {h_pos, h_neg} = edge_pair(Sync_pre[SYNC_H], Sync_cur[SYNC_H], ~nDSYNC);
    timeout        = (line_cnt == LINE_MAX);
    // Field parity flips every field only in interlaced modes.
    cand.n64_480i  = (h_neg != field_o);
    cand.vmode     = ({1'b0, fld_lines} > PAL_LIM);
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      data_cnt  <= '0;
      line_cnt  <= '0;
      fld_lines <= '0;
      field_o   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      data_cnt <= nDSYNC ? data_cnt + 1'b1 : DCNT_W'(1);

      // A vertical sync edge restarts the count even if a line edge coincides with it.
      if (v_pos) begin
        fld_lines <= line_cnt;
        line_cnt  <= '0;
      end else if (h_pos && !timeout) begin
        line_cnt <= line_cnt + 1'b1;
      end

      if (v_neg) field_o <= h_neg;
    end
  end

  n64_vinfo_filter #(
    .W           ($bits(vinfo_cand_t)),
    .LOCK_FRAMES (LOCK_FRAMES),
    .RST_VAL     (VINFO_RST)
  ) u_filter (
    .clk     (VCLK),
    .rst     (RST),
    .cand    (cand),
    .valid   (v_neg),
    .timeout (timeout),
    .value   (vinfo_q),
    .locked  (locked_o)
  );

  always_comb begin
    // NOTE: the whole vector gets a default before the field writes, so no bit is left
    // unassigned on any path and no latch is inferred.
    vinfo_o                        = '0;
    vinfo_o[VINFO_DCNT +: DCNT_W]  = data_cnt;
    vinfo_o[VINFO_480I]            = vinfo_q.n64_480i;
    vinfo_o[VINFO_VMODE]           = vinfo_q.vmode;
  end

`ifdef N64_VINFO_LINECNT_EN
  assign fld_lines_o = fld_lines;
`endif

endmodule

// File: tb/tb_n64_vinfo_track.sv
// Directed bench for n64_vinfo_track: data phase, NTSC/PAL lock, mode switch, timeout,
// coincident sync edges and mid-field reset. Each field decision uses the previous field's count.
module tb_n64_vinfo_track;

  logic       VCLK = 1'b0;
  logic       RST;
  logic       nDSYNC;
  logic [3:0] Sync_pre;
  logic [3:0] Sync_cur;
  logic [3:0] vinfo_o;
  logic       locked_o;
  logic       field_o;
`ifdef N64_VINFO_LINECNT_EN
  logic [9:0] fld_lines_o;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  logic v_lvl    = 1'b1;
  logic h_lvl    = 1'b1;

  always #5 VCLK = ~VCLK;

  n64_vinfo_track dut (
    .VCLK     (VCLK),
    .RST      (RST),
    .nDSYNC   (nDSYNC),
    .Sync_pre (Sync_pre),
    .Sync_cur (Sync_cur),
    .vinfo_o  (vinfo_o),
    .locked_o (locked_o),
`ifdef N64_VINFO_LINECNT_EN
    .fld_lines_o (fld_lines_o),
`endif
    .field_o  (field_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  // One sync-nibble cycle followed by gap-1 data cycles; edges on data cycles must be ignored.
  task automatic send(input logic v, input logic h, input int gap);
    Sync_pre = {v_lvl, 1'b0, h_lvl, 1'b0};
    Sync_cur = {v, 1'b0, h, 1'b0};
    nDSYNC   = 1'b0;
    tick();
    nDSYNC   = 1'b1;
    repeat (gap - 1) tick();
    v_lvl = v;
    h_lvl = h;
  endtask

  task automatic lines(input int n);
    repeat (n) begin
      send(v_lvl, 1'b0, 2);
      send(v_lvl, 1'b1, 2);
    end
  endtask

  // n lines, then a vsync pulse; odd fields drop nHSYNC with nVSYNC and raise both together.
  task automatic field(input int n, input logic odd);
    lines(n);
    send(1'b0, ~odd, 2);
    send(1'b1, 1'b1, 2);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    nDSYNC   = 1'b1;
    Sync_pre = 4'b1010;
    Sync_cur = 4'b1010;
    v_lvl    = 1'b1;
    h_lvl    = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    logic [1:0] dcnt_exp [6];
    dcnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

    // Reset state and data phase counter
    do_reset();
    check("rst_vinfo", vinfo_o, 4'b0010);
    check("rst_locked", locked_o, 0);
    check("rst_field", field_o, 0);
    for (int i = 0; i < 6; i++) begin
      nDSYNC = (i % 4 == 0) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("dcnt_%0d", i), vinfo_o[3:2], dcnt_exp[i]);
    end
    nDSYNC = 1'b1;
    RST    = 1'b1;
    tick();
    check("dcnt_rst", vinfo_o[3:2], 0);
    RST = 1'b0;

    // NTSC 240p: all even fields, 263 lines
    do_reset();
    repeat (3) field(263, 1'b0);
    check("ntsc_f3_locked", locked_o, 0);
    check("ntsc_f3_mode", vinfo_o[1:0], 2'b10);
    field(263, 1'b0);
    check("ntsc_f4_locked", locked_o, 1);
    check("ntsc_f4_mode", vinfo_o[1:0], 2'b00);
    check("ntsc_field", field_o, 0);

    // Switch to 313 lines: the first decision still sees a 263-line field
    field(313, 1'b0);
    check("sw_f1_locked", locked_o, 1);
    field(313, 1'b0);
    check("sw_f2_locked", locked_o, 0);
    check("sw_f2_mode_hold", vinfo_o[1:0], 2'b00);
    repeat (2) field(313, 1'b0);
    check("sw_f4_locked", locked_o, 0);
    field(313, 1'b0);
    check("sw_f5_locked", locked_o, 1);
    check("sw_f5_mode", vinfo_o[1:0], 2'b01);

    // Timeout: nVSYNC stops, line counter saturates
    lines(1022);
    check("to_1022_locked", locked_o, 1);
    lines(1);
    check("to_1023_locked", locked_o, 0);
    check("to_1023_cnt", dut.line_cnt, 1023);
    lines(5);
    check("to_sat_cnt", dut.line_cnt, 1023);
    check("to_mode_hold", vinfo_o[1:0], 2'b01);

    // PAL 576i: one priming field, then four alternating odd/even fields
    do_reset();
    field(313, 1'b0);
    field(312, 1'b1);
    field(313, 1'b0);
    field(312, 1'b1);
    check("pal_f4_locked", locked_o, 0);
    check("pal_f4_field", field_o, 1);
    field(313, 1'b0);
    check("pal_f5_locked", locked_o, 1);
    check("pal_f5_mode", vinfo_o[1:0], 2'b11);
    check("pal_f5_field", field_o, 0);

    // Coincident posedge nVSYNC/nHSYNC: line count restarts at 0, no extra line
    do_reset();
    lines(7);
    check("co_pre_cnt", dut.line_cnt, 7);
    send(1'b0, 1'b0, 2);
    send(1'b1, 1'b1, 2);
    check("co_cnt", dut.line_cnt, 0);
`ifdef N64_VINFO_LINECNT_EN
    check("co_fld_lines", fld_lines_o, 7);
`endif
    check("co_field_odd", field_o, 1);

    // Reset mid-field clears counting and field ID
    lines(4);
    check("mid_pre_cnt", dut.line_cnt, 4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_cnt", dut.line_cnt, 0);
    check("mid_rst_field", field_o, 0);
    check("mid_rst_vinfo", vinfo_o[1:0], 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
